ifu_fetch: RTL and testbench
============================

// Module: ifu_fetch
// PURPOSE
//  PC holder and instruction fetcher at the front of the NPC core; consumes exu_pc-style next-PC
//  results (pc_in/pc_w_en) and supplies the current PC back to EXU. Issues one instruction read
//  per PC over a valid/ready imem port and hands the fetched word to IDU via valid/ready.
//  Single outstanding fetch; next fetch starts only after EXU commits a new PC.
// PARAMETERS
//  RESET_PC    32'h8000_0000  PC value loaded on reset
//  ISA_WIDTH   32             PC / address / data width (tracks `ISA_WIDTH)
// PORTS
//  clk            in   1          clock; all state updates on rising edge
//  rst            in   1          synchronous, active-high reset
//  pc_in          in   ISA_WIDTH  next PC from EXU
//  pc_w_en        in   1          EXU commit strobe: load pc_in into PC
//  pc_out         out  ISA_WIDTH  current PC (to EXU, IDU)
//  imem_req_valid out  1          fetch request valid
//  imem_req_ready in   1          memory accepts request
//  imem_req_addr  out  ISA_WIDTH  fetch address (= pc_out)
//  imem_rsp_valid in   1          read data valid (one-cycle pulse)
//  imem_rsp_data  in   32         instruction word
//  inst_valid     out  1          inst holds a fetched word for IDU
//  inst_ready     in   1          IDU/EXU accepts inst
//  inst           out  32         fetched instruction
//  fetch_err      out  1          sticky: misaligned PC committed; fetch halted
//  fetch_cnt      out  32         number of instructions handed to IDU (wraps)
// BEHAVIOUR
//  Reset: pc_out=RESET_PC, state=REQ, imem_req_valid=0 in reset cycle, inst_valid=0, inst=0,
//   fetch_err=0, fetch_cnt=0. Reset in any state aborts the fetch; a late imem_rsp_valid is
//   dropped because state is REQ, not WAIT.
//  States: REQ, WAIT, HOLD, EXEC, HALT.
//   REQ : imem_req_valid=1, addr=pc_out; on imem_req_ready -> WAIT (handshake same cycle).
//   WAIT: on imem_rsp_valid latch inst<=imem_rsp_data -> HOLD. Responses seen in any other
//         state are ignored.
//   HOLD: inst_valid=1, inst and pc_out stable. On inst_ready: fetch_cnt+=1; if pc_w_en in the
//         same cycle (single-cycle EXU) load PC -> REQ, else -> EXEC.
//   EXEC: inst_valid=0; on pc_w_en load PC -> REQ; otherwise wait indefinitely (ebreak/illegal
//         leave pc_w_en=0, so core stalls here).
//  pc_w_en in REQ/WAIT, or in HOLD without inst_ready, is ignored; PC unchanged.
//  PC load: if pc_in[1:0]!=0 -> PC still loaded, fetch_err<=1, -> HALT (no request ever issued).
//   HALT exits only via rst.
//  Latency: REQ->HOLD minimum 2 cycles (ready same cycle, rsp next cycle); with zero-wait imem
//   and inst_ready=pc_w_en=1 the steady rate is 1 instruction per 3 cycles.
//  fetch_cnt: 32-bit, wraps 0xFFFF_FFFF -> 0; no saturation.
// STRUCTURE
//  config.vh: `ISA_WIDTH, `RESET_PC. New ifu.vh: state encodings `IFU_REQ..`IFU_HALT,
//   `IFU_STATE_WIDTH.
//  One sub-module ifu_pc_reg: PC register with sync reset to RESET_PC, load enable, and
//   misalignment check output; FSM, inst latch and counter stay in ifu_fetch.
// TESTING
//  1 rst high 2 cycles, drop -> pc_out=0x8000_0000, first req addr 0x8000_0000 on next cycle.
//  2 zero-wait imem returns 0x0000_0013; inst_ready=1, pc_w_en=1, pc_in=0x8000_0004 ->
//    next req addr 0x8000_0004, fetch_cnt=1, steady 3 cycles/inst.
//  3 imem_req_ready low 5 cycles, rsp delayed 3 cycles -> req_valid/addr held stable, inst and
//    pc_out held in HOLD while inst_ready=0.
//  4 accept inst with pc_w_en=0 for 4 cycles, then pc_w_en with pc_in=0x8000_0100 -> stays in
//    EXEC, then fetches 0x8000_0100; pc_w_en pulses during WAIT have no effect.
//  5 commit pc_in=0x8000_0102 -> fetch_err=1, no further imem_req_valid; rst clears it.
//  6 assert rst while in WAIT, rsp arrives the cycle after -> dropped, inst_valid stays 0,
//    refetch from 0x8000_0000.

Source files
------------

// File: rtl/ifu_fetch_pkg.sv
// Shared types, widths and defaults for the instruction fetch unit.
package ifu_fetch_pkg;

  localparam int unsigned DEFAULT_ISA_WIDTH = 32;
  localparam int unsigned INST_WIDTH        = 32;
  localparam int unsigned CNT_WIDTH         = 32;
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h8000_0000;

  typedef enum logic [2:0] {
    IFU_REQ  = 3'd0,
    IFU_WAIT = 3'd1,
    IFU_HOLD = 3'd2,
    IFU_EXEC = 3'd3,
    IFU_HALT = 3'd4
  } ifu_state_e;

  // Instruction fetches must be word aligned.
  function automatic logic pc_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_pc_reg.sv
// Program counter register: synchronous reset to RESET_PC, load enable,
// and an alignment flag for the PC being offered for load.
module ifu_pc_reg
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned          ISA_WIDTH = DEFAULT_ISA_WIDTH,
  parameter logic [ISA_WIDTH-1:0] RESET_PC  = ISA_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [ISA_WIDTH-1:0] pc_in,
  output logic [ISA_WIDTH-1:0] pc,
  output logic                 misaligned_c
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= pc_in;
    end
  end

  assign misaligned_c = pc_misaligned(pc_in[1:0]);

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the PC, issues one imem read per committed PC
// and presents the fetched word to IDU; one fetch outstanding at a time.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned          ISA_WIDTH = DEFAULT_ISA_WIDTH,
  parameter logic [ISA_WIDTH-1:0] RESET_PC  = ISA_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ISA_WIDTH-1:0]  pc_in,
  input  logic                  pc_w_en,
  output logic [ISA_WIDTH-1:0]  pc_out,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ISA_WIDTH-1:0]  imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  fetch_err,
  output logic [CNT_WIDTH-1:0]  fetch_cnt
);

  ifu_state_e state;
  logic       pc_load_c;
  logic       pc_bad_c;

  // A commit only counts once the current instruction has been taken by IDU.
  assign pc_load_c = pc_w_en && (((state == IFU_HOLD) && inst_ready) || (state == IFU_EXEC));
  assign imem_req_addr = pc_out;

  ifu_pc_reg #(
    .ISA_WIDTH (ISA_WIDTH),
    .RESET_PC  (RESET_PC)
  ) u_pc_reg (
    .clk          (clk),
    .rst          (rst),
    .load         (pc_load_c),
    .pc_in        (pc_in),
    .pc           (pc_out),
    .misaligned_c (pc_bad_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IFU_REQ;
      imem_req_valid <= 1'b0;
      inst_valid     <= 1'b0;
      inst           <= '0;
      fetch_err      <= 1'b0;
      fetch_cnt      <= '0;
    end else begin
      case (state)
        IFU_REQ: begin
          if (imem_req_valid && imem_req_ready) begin
            state          <= IFU_WAIT;
            imem_req_valid <= 1'b0;
          end else begin
            imem_req_valid <= 1'b1;
          end
        end
        IFU_WAIT: begin
          if (imem_rsp_valid) begin
            inst       <= imem_rsp_data;
            inst_valid <= 1'b1;
            state      <= IFU_HOLD;
          end
        end
        IFU_HOLD: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            fetch_cnt  <= fetch_cnt + CNT_WIDTH'(1);
            state      <= IFU_EXEC;
          end
        end
        IFU_EXEC: begin
        end
        IFU_HALT: begin
        end
        default: state <= IFU_HALT;
      endcase

      // New PC overrides the HOLD/EXEC successor; a misaligned PC halts fetch for good.
      if (pc_load_c) begin
        if (pc_bad_c) begin
          fetch_err <= 1'b1;
          state     <= IFU_HALT;
        end else begin
          imem_req_valid <= 1'b1;
          state          <= IFU_REQ;
        end
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: reactive imem model plus directed scenarios and a
// randomized run checked against a transaction-level PC/fetch model.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_in = '0;
  logic        pc_w_en = 1'b0;
  logic [31:0] pc_out;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic        fetch_err;
  logic [31:0] fetch_cnt;

  int n_pass  = 0;
  int n_total = 0;

  int ready_lat = 0;
  int rsp_lat   = 1;
  bit spur_en   = 1'b0;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .pc_w_en        (pc_w_en),
    .pc_out         (pc_out),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .fetch_err      (fetch_err),
    .fetch_cnt      (fetch_cnt)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h8000_0013;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory: grants after ready_lat cycles of request, answers rsp_lat cycles after the handshake.
  initial begin : imem_model
    int          wait_cnt;
    int          countdown;
    logic [31:0] paddr;
    wait_cnt = 0;
    countdown = 0;
    paddr = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      tick();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(paddr);
        end
      end else if (spur_en && $urandom_range(0, 3) == 0) begin
        imem_rsp_valid = 1'b1;
      end
      imem_req_ready = 1'b0;
      if (rst) begin
        wait_cnt = 0;
      end else if (imem_req_valid && countdown == 0) begin
        if (wait_cnt >= ready_lat) begin
          imem_req_ready = 1'b1;
          countdown = rsp_lat;
          paddr = imem_req_addr;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    pc_w_en = 1'b0;
    inst_ready = 1'b0;
    pc_in = '0;
    repeat (6) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_total++;
    if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); else n_pass++;
    n_total++;
    if (pc_out !== RST_PC) $display("FAIL reset_pc: got %h want %h", pc_out, RST_PC); else n_pass++;
    n_total++;
    if ({inst_valid, fetch_err} !== 2'b00 || inst !== 32'h0 || fetch_cnt !== 32'h0)
      $display("FAIL reset_outputs: got iv=%b err=%b inst=%h cnt=%h want all zero", inst_valid, fetch_err, inst, fetch_cnt);
    else n_pass++;
    tick();
    rst = 1'b0;
    tick();
    n_total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC)
      $display("FAIL reset_first_req: got v=%b addr=%h want 1/%h", imem_req_valid, imem_req_addr, RST_PC);
    else n_pass++;
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_pc;
    int          acc[$];
    ready_lat = 0; rsp_lat = 1; spur_en = 1'b0;
    do_reset();
    exp_pc = RST_PC;
    for (int c = 0; c < 20; c++) begin
      n_total++;
      if (fetch_cnt !== 32'(acc.size())) $display("FAIL zw_cnt: got %0d want %0d", fetch_cnt, acc.size()); else n_pass++;
      if (imem_req_valid) begin
        n_total++;
        if (imem_req_addr !== exp_pc) $display("FAIL zw_req_addr: got %h want %h", imem_req_addr, exp_pc); else n_pass++;
      end
      inst_ready = 1'b1;
      pc_w_en = 1'b1;
      pc_in = exp_pc + 32'd4;
      if (inst_valid) begin
        n_total++;
        if (inst !== mem_word(exp_pc) || (acc.size() == 0 && inst !== 32'h0000_0013))
          $display("FAIL zw_inst: got %h want %h", inst, mem_word(exp_pc));
        else n_pass++;
        acc.push_back(c);
        exp_pc = exp_pc + 32'd4;
      end
      tick();
    end
    inst_ready = 1'b0;
    pc_w_en = 1'b0;
    n_total++;
    if (acc.size() < 4) $display("FAIL zw_accepts: got %0d want >=4", acc.size());
    else if (acc[0] != 2 || acc[2] - acc[1] != 3 || acc[3] - acc[2] != 3)
      $display("FAIL zw_rate: got first=%0d gaps=%0d,%0d want 2,3,3", acc[0], acc[2] - acc[1], acc[3] - acc[2]);
    else n_pass++;
  endtask

  task automatic test_stall();
    int lat;
    ready_lat = 5; rsp_lat = 3; spur_en = 1'b0;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      n_total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC)
        $display("FAIL stall_req_hold: got v=%b addr=%h want 1/%h", imem_req_valid, imem_req_addr, RST_PC);
      else n_pass++;
      tick();
    end
    lat = 0;
    while (!inst_valid && lat < 10) begin
      tick();
      lat++;
    end
    n_total++;
    if (lat != 4) $display("FAIL stall_rsp_latency: got %0d want 4", lat); else n_pass++;
    inst_ready = 1'b0;
    pc_w_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      pc_in = RST_PC + 32'($urandom_range(1, 63) << 2);
      tick();
      n_total++;
      if (inst_valid !== 1'b1 || inst !== 32'h0000_0013 || pc_out !== RST_PC)
        $display("FAIL stall_hold: got iv=%b inst=%h pc=%h want 1/00000013/%h", inst_valid, inst, pc_out, RST_PC);
      else n_pass++;
    end
    inst_ready = 1'b1;
    pc_in = 32'h8000_0008;
    tick();
    inst_ready = 1'b0;
    pc_w_en = 1'b0;
    n_total++;
    if (fetch_cnt !== 32'd1 || inst_valid !== 1'b0) $display("FAIL stall_accept: got cnt=%0d iv=%b want 1/0", fetch_cnt, inst_valid); else n_pass++;
    n_total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0008)
      $display("FAIL stall_next_req: got v=%b addr=%h want 1/80000008", imem_req_valid, imem_req_addr);
    else n_pass++;
  endtask

  task automatic test_exec_wait();
    int n;
    ready_lat = 0; rsp_lat = 2; spur_en = 1'b0;
    do_reset();
    pc_w_en = 1'b1;
    pc_in = 32'h8000_0040;
    n = 0;
    while (!inst_valid && n < 10) begin
      tick();
      n++;
    end
    n_total++;
    if (inst_valid !== 1'b1 || pc_out !== RST_PC)
      $display("FAIL exec_early_commit: got iv=%b pc=%h want 1/%h", inst_valid, pc_out, RST_PC);
    else n_pass++;
    inst_ready = 1'b1;
    pc_w_en = 1'b0;
    tick();
    inst_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_total++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0 || pc_out !== RST_PC)
        $display("FAIL exec_stall: got iv=%b rv=%b pc=%h want 0/0/%h", inst_valid, imem_req_valid, pc_out, RST_PC);
      else n_pass++;
      tick();
    end
    pc_w_en = 1'b1;
    pc_in = 32'h8000_0100;
    tick();
    pc_w_en = 1'b0;
    n_total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100 || pc_out !== 32'h8000_0100)
      $display("FAIL exec_commit: got v=%b addr=%h pc=%h want 1/80000100", imem_req_valid, imem_req_addr, pc_out);
    else n_pass++;
    n = 0;
    while (!inst_valid && n < 10) begin
      tick();
      n++;
    end
    n_total++;
    if (inst_valid !== 1'b1 || inst !== 32'h0000_0113 || fetch_cnt !== 32'd1)
      $display("FAIL exec_refetch: got iv=%b inst=%h cnt=%0d want 1/00000113/1", inst_valid, inst, fetch_cnt);
    else n_pass++;
  endtask

  task automatic test_misaligned();
    int n;
    bit bad;
    ready_lat = 0; rsp_lat = 1; spur_en = 1'b0;
    do_reset();
    n = 0;
    while (!inst_valid && n < 10) begin
      tick();
      n++;
    end
    inst_ready = 1'b1;
    pc_w_en = 1'b1;
    pc_in = 32'h8000_0102;
    tick();
    n_total++;
    if (fetch_err !== 1'b1 || pc_out !== 32'h8000_0102 || fetch_cnt !== 32'd1)
      $display("FAIL misalign_commit: got err=%b pc=%h cnt=%0d want 1/80000102/1", fetch_err, pc_out, fetch_cnt);
    else n_pass++;
    bad = 1'b0;
    for (int c = 0; c < 12; c++) begin
      inst_ready = 1'($urandom_range(0, 1));
      pc_w_en = 1'($urandom_range(0, 1));
      pc_in = RST_PC + 32'($urandom_range(0, 63) << 2);
      tick();
      if (imem_req_valid || !fetch_err || inst_valid) bad = 1'b1;
    end
    inst_ready = 1'b0;
    pc_w_en = 1'b0;
    n_total++;
    if (bad) $display("FAIL misalign_halt: got activity after halt want none"); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++;
    if (fetch_err !== 1'b0 || pc_out !== RST_PC) $display("FAIL misalign_rst_clear: got err=%b pc=%h want 0/%h", fetch_err, pc_out, RST_PC); else n_pass++;
    n = 0;
    while (!inst_valid && n < 10) begin
      tick();
      n++;
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    pc_w_en = 1'b1;
    pc_in = 32'h8000_0201;
    tick();
    pc_w_en = 1'b0;
    tick();
    n_total++;
    if (fetch_err !== 1'b1 || imem_req_valid !== 1'b0)
      $display("FAIL misalign_from_exec: got err=%b rv=%b want 1/0", fetch_err, imem_req_valid);
    else n_pass++;
  endtask

  task automatic test_reset_in_wait();
    int n;
    ready_lat = 0; rsp_lat = 2; spur_en = 1'b0;
    do_reset();
    tick();
    n_total++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) $display("FAIL rw_in_wait: got rv=%b iv=%b want 0/0", imem_req_valid, inst_valid); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    n_total++;
    if (inst_valid !== 1'b0 || inst !== 32'h0) $display("FAIL rw_late_rsp: got iv=%b inst=%h want 0/0", inst_valid, inst); else n_pass++;
    n_total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC)
      $display("FAIL rw_refetch_req: got v=%b addr=%h want 1/%h", imem_req_valid, imem_req_addr, RST_PC);
    else n_pass++;
    n = 0;
    while (!inst_valid && n < 10) begin
      tick();
      n++;
    end
    n_total++;
    if (inst_valid !== 1'b1 || inst !== 32'h0000_0013 || fetch_cnt !== 32'd0)
      $display("FAIL rw_refetch: got iv=%b inst=%h cnt=%0d want 1/00000013/0", inst_valid, inst, fetch_cnt);
    else n_pass++;
  endtask

  // Model: PC changes only on a commit made with or after IDU takes the word; one fetch per PC.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    bit          awaiting;
    bit          acc;
    bit          commit;
    bit          bad;
    spur_en = 1'b1;
    do_reset();
    exp_pc = RST_PC;
    exp_cnt = '0;
    awaiting = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      n_total++;
      if (pc_out !== exp_pc || fetch_cnt !== exp_cnt) begin
        if (!bad) $display("FAIL rnd_state: cycle %0d got pc=%h cnt=%0d want %h/%0d", c, pc_out, fetch_cnt, exp_pc, exp_cnt);
        bad = 1'b1;
      end else n_pass++;
      n_total++;
      if ((imem_req_valid && imem_req_addr !== exp_pc) || (awaiting && (inst_valid || imem_req_valid))) begin
        if (!bad) $display("FAIL rnd_fetch: cycle %0d got rv=%b addr=%h iv=%b want addr %h", c, imem_req_valid, imem_req_addr, inst_valid, exp_pc);
        bad = 1'b1;
      end else n_pass++;
      ready_lat = $urandom_range(0, 3);
      rsp_lat = $urandom_range(1, 4);
      inst_ready = 1'($urandom_range(0, 1));
      pc_w_en = ($urandom_range(0, 2) == 0);
      pc_in = RST_PC + 32'($urandom_range(0, 255) << 2);
      acc = inst_valid && inst_ready;
      if (acc) begin
        n_total++;
        if (inst !== mem_word(exp_pc)) begin
          if (!bad) $display("FAIL rnd_inst: cycle %0d got %h want %h", c, inst, mem_word(exp_pc));
          bad = 1'b1;
        end else n_pass++;
      end
      commit = pc_w_en && (acc || awaiting);
      tick();
      if (acc) exp_cnt = exp_cnt + 32'd1;
      if (commit) exp_pc = pc_in;
      awaiting = (acc || awaiting) && !commit;
    end
    spur_en = 1'b0;
    inst_ready = 1'b0;
    pc_w_en = 1'b0;
    n_total++;
    if (exp_cnt < 32'd200) $display("FAIL rnd_progress: got %0d fetches want >=200", exp_cnt); else n_pass++;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    test_reset();
    test_zero_wait();
    test_stall();
    test_exec_wait();
    test_misaligned();
    test_reset_in_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
